// File: rtl/aec_stream.sv
// aec_stream: single-pass infix hex expression evaluator (merged shunting-yard/eval)
// with valid/ready streams, error reporting and resync at '='.
`default_nettype none

module aec_stream #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        ascii_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              error,
    output logic [1:0]        err_code
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] S_ACCEPT = 3'd0;
    localparam logic [2:0] S_REDUCE = 3'd1;
    localparam logic [2:0] S_FINAL  = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] OP_LP  = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;
    localparam logic [1:0] OP_SUB = 2'd3;

    localparam logic [PW-1:0] FULL = PW'(DEPTH);
    localparam logic [PW-1:0] ONE  = PW'(1);
    localparam logic [PW-1:0] TWO  = PW'(2);

    logic [2:0]        state;
    logic [DATA_W-1:0] vstk [DEPTH];
    logic [1:0]        ostk [DEPTH];
    logic [PW-1:0]     vsp, osp;
    logic              expect_operand, digit_run, pend_close;
    logic [1:0]        pend_op, err_q;

    logic [AW-1:0]     vi1, vi2, oi1, oi2;
    logic [DATA_W-1:0] vtop, vsec, red;
    logic [1:0]        otop, osec, in_op;
    logic              is_digit, is_op;
    logic [3:0]        dval;

    // '(' never reduces; '*' binds tighter than '+'/'-', ties reduce (left-assoc)
    function automatic logic prec_ge(input logic [1:0] top, input logic [1:0] inc);
        return (top != OP_LP) && ((top == OP_MUL) || (inc != OP_MUL));
    endfunction

    assign vi1  = AW'(vsp - ONE);
    assign vi2  = AW'(vsp - TWO);
    assign oi1  = AW'(osp - ONE);
    assign oi2  = AW'(osp - TWO);
    assign vtop = vstk[vi1];
    assign vsec = vstk[vi2];
    assign otop = ostk[oi1];
    assign osec = ostk[oi2];

    assign in_ready = (state == S_ACCEPT) || (state == S_FLUSH);

    always_comb begin
        red = vtop;
        case (otop)
            OP_MUL:  red = vsec * vtop;
            OP_ADD:  red = vsec + vtop;
            OP_SUB:  red = vsec - vtop;
            default: red = vtop;
        endcase
    end

    always_comb begin
        is_digit = 1'b0;
        dval     = 4'd0;
        is_op    = 1'b0;
        in_op    = OP_LP;
        if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
            is_digit = 1'b1;
            dval     = ascii_in[3:0];
        end else if (ascii_in >= 8'h61 && ascii_in <= 8'h66) begin
            is_digit = 1'b1;
            dval     = ascii_in[3:0] + 4'd9;
        end
        case (ascii_in)
            8'h2a:   begin is_op = 1'b1; in_op = OP_MUL; end
            8'h2b:   begin is_op = 1'b1; in_op = OP_ADD; end
            8'h2d:   begin is_op = 1'b1; in_op = OP_SUB; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_ACCEPT;
            vsp            <= '0;
            osp            <= '0;
            expect_operand <= 1'b1;
            digit_run      <= 1'b0;
            pend_close     <= 1'b0;
            pend_op        <= OP_LP;
            err_q          <= 2'd0;
            out_valid      <= 1'b0;
            result         <= '0;
            error          <= 1'b0;
            err_code       <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                vstk[i] <= '0;
                ostk[i] <= OP_LP;
            end
        end else begin
            case (state)
                S_ACCEPT: if (in_valid) begin
                    if (is_digit) begin
                        if (expect_operand) begin
                            if (vsp == FULL) begin
                                err_q <= 2'd2; state <= S_FLUSH;
                            end else begin
                                vstk[vsp[AW-1:0]] <= DATA_W'(dval);
                                vsp               <= vsp + ONE;
                                expect_operand    <= 1'b0;
                                digit_run         <= 1'b1;
                            end
                        end else if (digit_run) begin
                            vstk[vi1] <= (vtop << 4) | DATA_W'(dval);
                        end else begin
                            err_q <= 2'd3; state <= S_FLUSH;
                        end
                    end else begin
                        digit_run <= 1'b0;
                        if (ascii_in == 8'h28) begin
                            if (!expect_operand) begin
                                err_q <= 2'd3; state <= S_FLUSH;
                            end else if (osp == FULL) begin
                                err_q <= 2'd2; state <= S_FLUSH;
                            end else begin
                                ostk[osp[AW-1:0]] <= OP_LP;
                                osp               <= osp + ONE;
                            end
                        end else if (is_op) begin
                            if (expect_operand) begin
                                err_q <= 2'd3; state <= S_FLUSH;
                            end else begin
                                expect_operand <= 1'b1;
                                if (osp != '0 && prec_ge(otop, in_op)) begin
                                    pend_op    <= in_op;
                                    pend_close <= 1'b0;
                                    state      <= S_REDUCE;
                                end else if (osp == FULL) begin
                                    err_q <= 2'd2; state <= S_FLUSH;
                                end else begin
                                    ostk[osp[AW-1:0]] <= in_op;
                                    osp               <= osp + ONE;
                                end
                            end
                        end else if (ascii_in == 8'h29) begin
                            if (expect_operand) begin
                                err_q <= 2'd3; state <= S_FLUSH;
                            end else begin
                                pend_close <= 1'b1;
                                state      <= S_REDUCE;
                            end
                        end else if (ascii_in == 8'h3d) begin
                            if (expect_operand) begin
                                state     <= S_DONE;
                                out_valid <= 1'b1;
                                result    <= '0;
                                error     <= 1'b1;
                                err_code  <= 2'd3;
                            end else begin
                                state <= S_FINAL;
                            end
                        end else begin
                            err_q <= 2'd1; state <= S_FLUSH;
                        end
                    end
                end

                S_REDUCE: begin
                    if (pend_close && osp == '0) begin
                        err_q <= 2'd3; state <= S_FLUSH;
                    end else if (pend_close && otop == OP_LP) begin
                        osp   <= osp - ONE;
                        state <= S_ACCEPT;
                    end else begin
                        vstk[vi2] <= red;
                        vsp       <= vsp - ONE;
                        if (pend_close) begin
                            // matching '(' exposed by this reduction is dropped in the same cycle
                            if (osp >= TWO && osec == OP_LP) begin
                                osp   <= osp - TWO;
                                state <= S_ACCEPT;
                            end else begin
                                osp <= osp - ONE;
                            end
                        end else if (osp >= TWO && prec_ge(osec, pend_op)) begin
                            osp <= osp - ONE;
                        end else begin
                            ostk[oi1] <= pend_op;
                            state     <= S_ACCEPT;
                        end
                    end
                end

                S_FINAL: begin
                    if (osp == '0) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= vtop;
                        error     <= 1'b0;
                        err_code  <= 2'd0;
                    end else if (otop == OP_LP) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        result    <= '0;
                        error     <= 1'b1;
                        err_code  <= 2'd3;
                    end else begin
                        vstk[vi2] <= red;
                        vsp       <= vsp - ONE;
                        osp       <= osp - ONE;
                    end
                end

                S_FLUSH: if (in_valid && ascii_in == 8'h3d) begin
                    state     <= S_DONE;
                    out_valid <= 1'b1;
                    result    <= '0;
                    error     <= 1'b1;
                    err_code  <= err_q;
                end

                S_DONE: if (out_ready) begin
                    state          <= S_ACCEPT;
                    out_valid      <= 1'b0;
                    vsp            <= '0;
                    osp            <= '0;
                    expect_operand <= 1'b1;
                    digit_run      <= 1'b0;
                    pend_close     <= 1'b0;
                    err_q          <= 2'd0;
                end

                default: state <= S_ACCEPT;
            endcase
        end
    end
endmodule

`default_nettype wire
